pulse_train_gen: RTL
====================

Name: pulse_train_gen

Overview:
Transmit-side counterpart of the edge monitor: a synchronous generator that drives a square-wave pulse train on a single output for edge-monitoring logic to consume.
- On a start request it emits N pulses with programmable high and low widths, then signals completion.
- One-cycle rise/fall strobes mark every edge it produces, so benches and monitors can cross-check edge counts.

Parameters:
CNT_W, 8, width of pulse-count input and internal pulse counter
LEN_W, 8, width of high/low phase-length inputs and internal phase counter

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
num_pulses  input  CNT_W  number of pulses to emit; latched on accepted start
high_len  input  LEN_W  cycles out stays 1 per pulse; latched on accepted start
low_len  input  LEN_W  cycles out stays 0 after each pulse; latched on accepted start
out  output  1  generated pulse train (registered)
busy  output  1  high from the cycle after an accepted start through the last LOW cycle
rise  output  1  one-cycle strobe, high in the first cycle out==1 of each pulse
fall  output  1  one-cycle strobe, high in the first cycle out==0 after each pulse
done  output  1  one-cycle strobe at end of train

Behaviour:
- Reset (rst_n=0, async): state=IDLE; out=0, busy=0, rise=0, fall=0, done=0; counters and latched params cleared. Reset mid-train aborts immediately with no done or fall strobe.
- All outputs are registered. rise, fall and done are single-cycle pulses.
- FSM states: IDLE, HIGH, LOW, FIN.
- IDLE, start=1 at edge t: latch num_pulses, high_len and low_len.
  - If num_pulses==0: go to FIN. busy stays 0 and out stays 0.
  - Else: go to HIGH. At edge t+1, out=1, rise=1, busy=1.
- Zero lengths: a latched high_len or low_len of 0 is treated as 1. Effective lengths Lh, Ll lie in 1..2^LEN_W-1.
- HIGH: out=1 for exactly Lh cycles, then go to LOW. The first LOW cycle has out=0 and fall=1.
- LOW: out=0 for exactly Ll cycles. Then:
  - pulses remaining: go to HIGH with rise=1;
  - last pulse: go to FIN.
- FIN: lasts one cycle with done=1 and busy=0, then returns to IDLE. start is not sampled in FIN.
  - Earliest restart is start=1 in the first IDLE cycle, giving out=1 two cycles after done.
- Period and latency: each pulse period is Lh+Ll cycles. For num_pulses=N>0, a train is N*(Lh+Ll) busy cycles, and done asserts N*(Lh+Ll)+1 cycles after the start edge.
- Inputs during a train: start while busy is ignored (not queued). Changes to num_pulses, high_len or low_len while busy have no effect.
- Strobe counts: exactly N rise strobes and N fall strobes per train. rise and fall are never asserted together.
- Counter wrap: the pulse counter counts down from the latched N and never wraps. The maximum N=2^CNT_W-1 must emit exactly that many pulses.

Optional Feature:
Macro PULSE_TRAIN_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in HIGH: the next cycle has out=0 and fall=1, then goes to FIN (done=1 one cycle later).
  - abort=1 in LOW: goes straight to FIN.
  - abort is ignored in IDLE and FIN. abort has priority over normal phase transitions in the same cycle.
- Undefined: no abort port; trains always run to completion.

Test Plan:
- Reset: rst_n low mid-HIGH of N=3, Lh=4 -> out, busy, rise, fall, done all 0 asynchronously; no done afterwards.
- Basic: start with N=3, Lh=2, Ll=3 -> out=1 at t+1, pattern 11000 repeated 3 times; rise/fall each count 3; done at t+16; busy high for 15 cycles.
- Zero cases: N=0 -> done at t+1, out never 1, busy never 1. N=2, Lh=0, Ll=0 -> out toggles 1,0,1,0; done at t+5.
- Ignored inputs: start=1 held high throughout train N=2, Lh=1, Ll=1, with num_pulses changed to 7 mid-train -> exactly 2 pulses and one done; a new train starts only in the first IDLE cycle after done.
- Maximum count: N=255, Lh=1, Ll=1 (CNT_W=8) -> exactly 255 rise strobes, done at t+511.
- Abort (PULSE_TRAIN_ABORT_EN): N=5, Lh=4, Ll=4, abort during the 2nd pulse's HIGH -> fall the next cycle, done one cycle later, rise count = 2.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits N square pulses with programmable high/low widths,
// one-cycle rise/fall strobes on every edge, and a done strobe at the end.
// Optional feature: define PULSE_TRAIN_ABORT_EN to add an `abort` input that
// cuts a running train short.
// Outputs are registered decodes of the FSM state, so every output lags the
// state register by one cycle (start at edge t -> out=1 at edge t+1).
module pulse_train_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef PULSE_TRAIN_ABORT_EN
  input  logic             abort,
`endif
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  output logic             out,
  output logic             busy,
  output logic             rise,
  output logic             fall,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic [CNT_W-1:0] w_pulse_cnt_nxt;
  logic [LEN_W-1:0] r_phase_cnt;
  logic [LEN_W-1:0] w_phase_cnt_nxt;
  logic [LEN_W-1:0] r_high_len;
  logic [LEN_W-1:0] w_high_len_nxt;
  logic [LEN_W-1:0] r_low_len;
  logic [LEN_W-1:0] w_low_len_nxt;

  logic             w_abort;
  logic             w_high_last;
  logic             w_low_last;

  logic             w_out;
  logic             w_busy;
  logic             w_rise;
  logic             w_fall;
  logic             w_done;

  logic             r_out;
  logic             r_busy;
  logic             r_rise;
  logic             r_fall;
  logic             r_done;

`ifdef PULSE_TRAIN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Latched lengths are always >= 1 while a train runs, so len-1 never wraps there.
  assign w_high_last = (r_phase_cnt == (r_high_len - LEN_W'(1)));
  assign w_low_last  = (r_phase_cnt == (r_low_len - LEN_W'(1)));

  // State, counter and parameter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pulse_cnt <= '0;
      r_phase_cnt <= '0;
      r_high_len  <= '0;
      r_low_len   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_phase_cnt <= w_phase_cnt_nxt;
      r_high_len  <= w_high_len_nxt;
      r_low_len   <= w_low_len_nxt;
    end
  end

  // Next-state, counter updates and output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_pulse_cnt_nxt = r_pulse_cnt;
    w_phase_cnt_nxt = r_phase_cnt;
    w_high_len_nxt  = r_high_len;
    w_low_len_nxt   = r_low_len;
    w_out           = 1'b0;
    w_busy          = 1'b0;
    w_rise          = 1'b0;
    w_fall          = 1'b0;
    w_done          = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pulse_cnt_nxt = num_pulses;
          w_phase_cnt_nxt = '0;
          w_high_len_nxt  = (high_len == '0) ? LEN_W'(1) : high_len;
          w_low_len_nxt   = (low_len == '0) ? LEN_W'(1) : low_len;
          w_state_nxt     = (num_pulses == '0) ? S_FIN : S_HIGH;
        end
      end

      S_HIGH: begin
        w_out  = 1'b1;
        w_busy = 1'b1;
        w_rise = (r_phase_cnt == '0);
        if (w_abort) begin
          // One forced LOW cycle gives the closing fall strobe, then FIN.
          w_state_nxt     = S_LOW;
          w_phase_cnt_nxt = '0;
          w_pulse_cnt_nxt = CNT_W'(1);
          w_low_len_nxt   = LEN_W'(1);
        end else if (w_high_last) begin
          w_state_nxt     = S_LOW;
          w_phase_cnt_nxt = '0;
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + LEN_W'(1);
        end
      end

      S_LOW: begin
        w_busy = 1'b1;
        w_fall = (r_phase_cnt == '0);
        if (w_abort) begin
          w_state_nxt     = S_FIN;
          w_phase_cnt_nxt = '0;
        end else if (w_low_last) begin
          w_phase_cnt_nxt = '0;
          if (r_pulse_cnt == CNT_W'(1)) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt     = S_HIGH;
            w_pulse_cnt_nxt = r_pulse_cnt - CNT_W'(1);
          end
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + LEN_W'(1);
        end
      end

      S_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= 1'b0;
      r_busy <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_out  <= w_out;
      r_busy <= w_busy;
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_done <= w_done;
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign rise = r_rise;
  assign fall = r_fall;
  assign done = r_done;

endmodule
